// File: rtl/leaf_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : leaf_out_arbiter
// Brief    : Round-robin scheduler that packs the leaf's user output streams
//            onto the single BFT egress stream, gated per port by a
//            configured destination and a freespace credit count.
// Revision : 1.0  initial release
// ============================================================================
module leaf_out_arbiter #(
    parameter int NUM_OUT_PORTS         = 4,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int PACKET_BITS           = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS,
    parameter int CREDIT_BITS           = 8,
    parameter int INIT_CREDIT           = 128,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    resend,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_user,
    input  logic [NUM_OUT_PORTS-1:0]                vld_user,
    output logic [NUM_OUT_PORTS-1:0]                ack_user,
    input  logic                                    cfg_we,
    input  logic [$clog2(NUM_OUT_PORTS)-1:0]        cfg_port,
    input  logic [NUM_LEAF_BITS-1:0]                cfg_leaf,
    input  logic [NUM_PORT_BITS-1:0]                cfg_dport,
    input  logic                                    credit_upd,
    input  logic [$clog2(NUM_OUT_PORTS)-1:0]        credit_port,
    output logic [PACKET_BITS-1:0]                  dout_pkt,
    input  logic                                    out_rdy
);

    localparam int SEL_BITS = $clog2(NUM_OUT_PORTS);
    // Two guard bits let add-then-subtract be evaluated before saturating.
    localparam int SUM_BITS = CREDIT_BITS + 2;
    localparam logic [SUM_BITS-1:0] CREDIT_MAX = SUM_BITS'((1 << CREDIT_BITS) - 1);
    localparam logic [SUM_BITS-1:0] UPD_SIZE   = SUM_BITS'(FREESPACE_UPDATE_SIZE);

    logic [PACKET_BITS-1:0]   r_pkt;
    logic [SEL_BITS-1:0]      r_rr_ptr;

    logic [NUM_OUT_PORTS-1:0] w_elig;
    logic [PAYLOAD_BITS-1:0]  w_word  [NUM_OUT_PORTS];
    logic [NUM_LEAF_BITS-1:0] w_leaf  [NUM_OUT_PORTS];
    logic [NUM_PORT_BITS-1:0] w_dport [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] w_addr  [NUM_OUT_PORTS];

    logic                     w_can_load;
    logic                     w_grant_vld;
    logic                     w_take;
    logic [SEL_BITS-1:0]      w_grant;

    // The output slot can be refilled when empty or being drained, never while resending.
    assign w_can_load = (!r_pkt[PACKET_BITS-1] || out_rdy) && !resend;
    assign w_take     = w_can_load && w_grant_vld;

    // Per-port destination, sequence address and credit state.
    generate
        for (genvar i = 0; i < NUM_OUT_PORTS; i++) begin : g_port
            localparam logic [SEL_BITS-1:0] PORT_ID = SEL_BITS'(i);

            logic                     r_cfg_en;
            logic [NUM_LEAF_BITS-1:0] r_leaf;
            logic [NUM_PORT_BITS-1:0] r_dport;
            logic [NUM_ADDR_BITS-1:0] r_addr;
            logic [CREDIT_BITS-1:0]   r_credit;
            logic [CREDIT_BITS-1:0]   w_credit_nxt;
            logic                     w_cons;
            logic                     w_upd;

            assign w_cons     = w_take && (w_grant == PORT_ID);
            assign w_upd      = credit_upd && (credit_port == PORT_ID);
            assign w_elig[i]  = vld_user[i] && r_cfg_en && (r_credit != '0);
            assign w_word[i]  = din_user[i*PAYLOAD_BITS +: PAYLOAD_BITS];
            assign w_leaf[i]  = r_leaf;
            assign w_dport[i] = r_dport;
            assign w_addr[i]  = r_addr;

            // Next credit: apply update and consumption together, then saturate.
            always_comb begin
                logic [SUM_BITS-1:0] sum;
                sum = SUM_BITS'(r_credit);
                if (w_upd)  sum = sum + UPD_SIZE;
                if (w_cons) sum = sum - SUM_BITS'(1);
                w_credit_nxt = (sum > CREDIT_MAX) ? '1 : sum[CREDIT_BITS-1:0];
            end

            // Port state register: config writes, address advance, credit tracking.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_cfg_en <= 1'b0;
                    r_leaf   <= '0;
                    r_dport  <= '0;
                    r_addr   <= '0;
                    r_credit <= CREDIT_BITS'(INIT_CREDIT);
                end else begin
                    r_credit <= w_credit_nxt;
                    if (cfg_we && (cfg_port == PORT_ID)) begin
                        r_cfg_en <= 1'b1;
                        r_leaf   <= cfg_leaf;
                        r_dport  <= cfg_dport;
                    end
                    if (w_cons) r_addr <= r_addr + 1'b1;
                end
            end
        end
    endgenerate

    // Round-robin search starting just after the last winner.
    always_comb begin
        int                  idx;
        logic [SEL_BITS-1:0] sel;
        idx         = 0;
        sel         = '0;
        w_grant_vld = 1'b0;
        w_grant     = r_rr_ptr;
        for (int k = 1; k <= NUM_OUT_PORTS; k++) begin
            idx = (int'(r_rr_ptr) + k) % NUM_OUT_PORTS;
            sel = SEL_BITS'(idx);
            if (!w_grant_vld && w_elig[sel]) begin
                w_grant_vld = 1'b1;
                w_grant     = sel;
            end
        end
    end

    // Accept pulse goes to the winner in the same cycle as the decision.
    always_comb begin
        ack_user = '0;
        if (w_take) ack_user[w_grant] = 1'b1;
    end

    // Resend masks the output without disturbing the held packet.
    assign dout_pkt = resend ? '0 : r_pkt;

    // Output packet register and round-robin pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pkt    <= '0;
            r_rr_ptr <= SEL_BITS'(NUM_OUT_PORTS - 1);
        end else if (w_can_load) begin
            if (w_take) begin
                r_pkt    <= {1'b1, w_leaf[w_grant], w_dport[w_grant], w_addr[w_grant], w_word[w_grant]};
                r_rr_ptr <= w_grant;
            end else begin
                r_pkt    <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/leaf_out_arbiter.md
Name: leaf_out_arbiter

Overview:
- Schedules the NUM_OUT_PORTS user output streams of a leaf onto the single BFT-bound packet stream.
- Round-robin arbitration, gated per port by a configured destination and a freespace credit count.
- Packs the winning 32-bit word into a 49-bit BFT packet with a per-port sequence address.
- Sits between the user kernel outputs and the leaf's BFT egress; runs in the interface clock domain.

Parameters:
NUM_OUT_PORTS, 4, number of user output ports arbitrated
PAYLOAD_BITS, 32, user word width
PACKET_BITS, 49, BFT packet width = 1+NUM_LEAF_BITS+NUM_PORT_BITS+NUM_ADDR_BITS+PAYLOAD_BITS
NUM_LEAF_BITS, 5, destination leaf field width
NUM_PORT_BITS, 4, destination port field width
NUM_ADDR_BITS, 7, per-port sequence address width
CREDIT_BITS, 8, per-port credit counter width
INIT_CREDIT, 128, credit loaded at reset
FREESPACE_UPDATE_SIZE, 64, credits added per freespace update

Ports:
clk  in  1  interface clock
reset_n  in  1  asynchronous active-low reset
resend  in  1  freeze arbitration; force packet output to zero
din_user  in  NUM_OUT_PORTS*PAYLOAD_BITS  user words, port i at slice i
vld_user  in  NUM_OUT_PORTS  user word valid per port
ack_user  out  NUM_OUT_PORTS  one-cycle accept pulse per port
cfg_we  in  1  destination config write strobe
cfg_port  in  clog2(NUM_OUT_PORTS)  port being configured
cfg_leaf  in  NUM_LEAF_BITS  destination leaf
cfg_dport  in  NUM_PORT_BITS  destination port at that leaf
credit_upd  in  1  freespace update strobe
credit_port  in  clog2(NUM_OUT_PORTS)  port receiving the update
dout_pkt  out  PACKET_BITS  packet {valid, leaf, dport, addr, payload}
out_rdy  in  1  BFT egress can take dout_pkt this cycle

Behaviour:
- Reset (async assert, sync release): all per-port cfg_en=0, dest=0, addr=0, credit=INIT_CREDIT; rr_ptr=NUM_OUT_PORTS-1; output register=0; ack_user=0.
- Output register: dout_pkt is registered. The register holds a packet while dout_pkt[48]=1 and out_rdy=0.
- can_load = (!dout_pkt[48] || out_rdy) && !resend.
- Eligibility: port i is eligible if vld_user[i], cfg_en[i], and credit[i]!=0.
- Grant: when can_load, grant the first eligible port searching rr_ptr+1, rr_ptr+2, … with modulo wrap. Same-cycle combinational decision.
- On grant g:
  - ack_user[g]=1 for that cycle only.
  - Next cycle, dout_pkt = {1, dest_leaf[g], dest_dport[g], addr[g], din_user[g]}.
  - addr[g] increments and wraps from 2^NUM_ADDR_BITS-1 to 0.
  - credit[g] decrements.
  - rr_ptr = g.
- No grant while can_load: dout_pkt = 0 next cycle. rr_ptr holds.
- can_load=0: no ack; dout_pkt, rr_ptr, addr and credits hold, apart from credit updates and config writes.
- Latency: user word to dout_pkt is 1 cycle after ack. Throughput is one packet per cycle when out_rdy=1.
- Credit update: credit[credit_port] += FREESPACE_UPDATE_SIZE, saturating at 2^CREDIT_BITS-1.
- Update and consume on the same port in the same cycle: net result is credit + FREESPACE_UPDATE_SIZE - 1, with the same saturation.
- Config write: sets dest and cfg_en=1 for cfg_port. The new value applies from the next cycle's grant decision. addr is not reset.
- resend=1: the combinational dout_pkt output is forced to all zeros. The internal register keeps its packet, which reappears when resend drops. No acks are issued.
- Reset mid-operation: any in-flight dout_pkt is dropped; credits return to INIT_CREDIT.

Test Plan:
- Round-robin fairness: all 4 ports configured (leaf 3, dports 0..3), all vld held 1, out_rdy=1. Required: acks 0,1,2,3,0,… one per cycle; dout_pkt leaf field=3, dport=grant, addr increments per port.
- Credit exhaustion: INIT_CREDIT=2, port 1 only, vld=1. Required: exactly 2 acks then stall. One credit_upd on port 1 → 64 more acks.
- Backpressure: out_rdy=0 after the first packet. Required: dout_pkt stable with valid=1, no ack_user while held. out_rdy=1 → next packet the following cycle, no loss or duplication of payload 0xA5A5_0001, 0xA5A5_0002.
- Address wrap: 130 words on port 2. Required: addr field 0..127, then 0, 1.
- Simultaneous update/consume: credit=5, grant and credit_upd on the same port in the same cycle → credit=68. Saturation: credit=250 plus update → 255.
- resend and reset: resend=1 mid-stream → dout_pkt=0 and no acks, held packet reappears after release. Assert reset_n=0 mid-stream → outputs 0 immediately, cfg_en cleared, no grants until reconfigured.
